v_jk_bank_driver: RTL and testbench
===================================

Name: v_jk_bank_driver

Overview:
- Controller for the input side of a bank of W JK flip-flop cells: drives per-bit J/K excitation and a clock strobe, then reads back Q to check the result.
- Accepts one command at a time (LOAD / INC / DEC / TOGGLE) over a valid/ready handshake.
- Uses the JK excitation table to convert the current-to-target transition into J/K values.
- Sits between the sequencing logic and the register/counter datapath built from v_jkff_async cells.

Parameters:
- W, 4, bank width in bits (1..16).
- SETTLE, 1, idle cycles after the strobe before readback (0..15; 0 = no WAIT state).

Ports:
- clk  in  1  system clock; all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  2  00 LOAD, 01 INC, 10 DEC, 11 TOGGLE.
- cmd_data  in  W  LOAD value or TOGGLE mask; ignored for INC/DEC.
- jk_j  out  W  J inputs of bank.
- jk_k  out  W  K inputs of bank.
- jk_clk  out  1  bank clock strobe, registered, one clk cycle high per command.
- q_in  in  W  bank Q readback.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  readback mismatch on last command; holds until next accept.
- q_obs  out  W  q_in value captured in CHECK.

Behaviour:
- Reset (clr high, immediate): state=IDLE; jk_j=0, jk_k=0, jk_clk=0, done=0, err=0, q_obs=0; cmd_ready=1 once clr is released.
- The bank itself is not cleared by this block.
- Accept: cmd_valid & cmd_ready at a rising edge (E0) latches op and data and clears err. cmd_valid while busy is ignored, not queued.
- FSM, one cycle per state except WAIT: IDLE -> SAMPLE -> SETUP -> STROBE -> HOLD -> WAIT (SETTLE cycles, skipped when SETTLE=0) -> CHECK -> IDLE.
- SAMPLE: cur=q_in. Target computation, modulo 2^W:
  - LOAD: tgt=data.
  - INC: tgt=cur+1 (0xF->0x0 for W=4).
  - DEC: tgt=cur-1 (0x0->0xF).
  - TOGGLE: tgt=cur^data.
- SETUP: drive J/K per bit.
  - LOAD/INC/DEC:
    - 0->1: J=1, K=0.
    - 1->0: J=0, K=1.
    - 0->0 and 1->1: J=0, K=0 (don't-cares resolved to hold).
  - TOGGLE: J=K=data, no dependence on cur.
  - jk_clk=0 in SETUP.
- STROBE: jk_clk=1; J/K held stable.
- HOLD: jk_clk=0; J/K still held (hold time).
- WAIT: jk_clk=0; J/K still held.
- CHECK: q_obs<=q_in; err<=(q_in!=tgt).
- Leaving CHECK: done=1 for exactly the first IDLE cycle; J/K return to 0 at the same edge.
- Latency: done is high in the cycle after edge E(5+SETTLE); with SETTLE=1, done is high after E6.
- Exactly one jk_clk pulse per accepted command; jk_clk never high in any other state.
- Back-to-back: a command can be accepted in the done cycle (cmd_ready=1 there).
- clr mid-operation: outputs go to reset values immediately; the command is abandoned with no done and no err; the bank keeps whatever state it has.
- Simultaneous clr and accept edge: clr wins, command dropped.

Test Plan (bench instantiates W=4 v_jkff_async cells clocked by jk_clk, pre=0, with their own clr tied to the bench clr; SETTLE=1):
- Bank=0x0, LOAD 0xA -> in SETUP/STROBE/HOLD jk_j=1010, jk_k=0000; one jk_clk pulse; done after E6; q_obs=0xA; err=0.
- Bank=0xF, INC -> jk_j=0000, jk_k=1111; q_obs=0x0 (wrap); err=0.
- Bank=0x0, DEC -> jk_j=1111, jk_k=0000; q_obs=0xF (wrap); err=0.
- Bank=0xA, TOGGLE 0x5 -> jk_j=jk_k=0101; q_obs=0xF; then TOGGLE 0x5 accepted in the done cycle -> q_obs=0xA, exactly 2 jk_clk pulses total.
- Bench forces q_in[0] stuck at 0, LOAD 0x3 -> q_obs=0x2, err=1 with done; err stays 1 until next accept, then clears.
- clr asserted during STROBE -> jk_clk, jk_j, jk_k, done fall to 0 immediately; cmd_ready=1 after release; no done pulse. cmd_valid held high during a busy command -> no second accept until IDLE.

Source files
------------

// File: rtl/v_jk_bank_driver.sv
// Sequencer for a bank of W JK flip-flops: converts LOAD/INC/DEC/TOGGLE commands into
// J/K excitation plus a single clock strobe, then reads the bank back and flags mismatches.
module v_jk_bank_driver #(
    parameter int W      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [1:0]   cmd_op,
    input  logic [W-1:0] cmd_data,
    output logic [W-1:0] jk_j,
    output logic [W-1:0] jk_k,
    output logic         jk_clk,
    input  logic [W-1:0] q_in,
    output logic         done,
    output logic         err,
    output logic [W-1:0] q_obs
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_STROBE = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;
    localparam logic [2:0] S_CHECK  = 3'd6;

    localparam logic [1:0] OP_LOAD   = 2'b00;
    localparam logic [1:0] OP_INC    = 2'b01;
    localparam logic [1:0] OP_DEC    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    localparam logic [3:0] SETTLE_LD = 4'((SETTLE > 0) ? (SETTLE - 1) : 0);

    logic [2:0]   state;
    logic [1:0]   op_r;
    logic [W-1:0] data_r;
    logic [W-1:0] tgt_r;
    logic [3:0]   wait_cnt;
    logic [W-1:0] tgt_next;
    logic [W-1:0] j_next;
    logic [W-1:0] k_next;

    assign cmd_ready = (state == S_IDLE) && !clr;

    // Target is derived from the live readback while in SAMPLE, wrapping modulo 2^W.
    always_comb begin
        tgt_next = data_r;
        case (op_r)
            OP_LOAD:   tgt_next = data_r;
            OP_INC:    tgt_next = q_in + W'(1);
            OP_DEC:    tgt_next = q_in - W'(1);
            OP_TOGGLE: tgt_next = q_in ^ data_r;
            default:   tgt_next = data_r;
        endcase
    end

    // Excitation table with don't-cares resolved to hold; TOGGLE drives J=K=mask directly.
    always_comb begin
        j_next = tgt_next & ~q_in;
        k_next = q_in & ~tgt_next;
        if (op_r == OP_TOGGLE) begin
            j_next = data_r;
            k_next = data_r;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state    <= S_IDLE;
            op_r     <= OP_LOAD;
            data_r   <= '0;
            tgt_r    <= '0;
            wait_cnt <= '0;
            jk_j     <= '0;
            jk_k     <= '0;
            jk_clk   <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            q_obs    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_r   <= cmd_op;
                        data_r <= cmd_data;
                        err    <= 1'b0;
                        state  <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    tgt_r <= tgt_next;
                    jk_j  <= j_next;
                    jk_k  <= k_next;
                    state <= S_SETUP;
                end
                S_SETUP: begin
                    jk_clk <= 1'b1;
                    state  <= S_STROBE;
                end
                S_STROBE: begin
                    jk_clk <= 1'b0;
                    state  <= S_HOLD;
                end
                S_HOLD: begin
                    if (SETTLE == 0) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= SETTLE_LD;
                        state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == 4'd0) state <= S_CHECK;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                S_CHECK: begin
                    q_obs <= q_in;
                    err   <= (q_in != tgt_r);
                    done  <= 1'b1;
                    jk_j  <= '0;
                    jk_k  <= '0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_v_jk_bank_driver.sv
// Bench for v_jk_bank_driver: a behavioural JK bank closes the loop, directed vectors
// cover the documented scenarios and random commands are checked against an arithmetic model.
module tb_v_jk_bank_driver;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clr = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic [W-1:0] jk_j, jk_k;
    logic         jk_clk;
    logic [W-1:0] q_in;
    logic         done, err;
    logic [W-1:0] q_obs;

    logic [W-1:0] bank_q;
    logic [W-1:0] stuck = '0;
    int           pulses = 0;
    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] model_bank;

    always #5 clk = ~clk;

    v_jk_bank_driver #(.W(W), .SETTLE(1)) dut (
        .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .jk_j(jk_j), .jk_k(jk_k),
        .jk_clk(jk_clk), .q_in(q_in), .done(done), .err(err), .q_obs(q_obs)
    );

    // Behavioural JK bank, pre tied low, its clear shared with the driver's.
    always @(posedge jk_clk or posedge clr) begin
        if (clr) bank_q <= '0;
        else     bank_q <= (jk_j & ~bank_q) | (~jk_k & bank_q);
    end
    always @(posedge jk_clk) pulses++;

    assign q_in = bank_q & ~stuck;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: per-bit transition table applied to arithmetic targets.
    function automatic void model(input logic [1:0] op, input logic [3:0] data, input logic [3:0] cur,
                                  output logic [3:0] tgt, output logic [3:0] j, output logic [3:0] k);
        int t;
        case (op)
            2'b00:   t = data;
            2'b01:   t = (cur + 1) % 16;
            2'b10:   t = (cur + 15) % 16;
            default: t = cur ^ data;
        endcase
        tgt = 4'(t);
        for (int b = 0; b < 4; b++) begin
            if (op == 2'b11) begin
                j[b] = data[b];
                k[b] = data[b];
            end else if (cur[b] == tgt[b]) begin
                j[b] = 1'b0;
                k[b] = 1'b0;
            end else begin
                j[b] = tgt[b];
                k[b] = ~tgt[b];
            end
        end
    endfunction

    // Starts at a negedge with the driver idle; returns at the negedge of the done cycle.
    task automatic run_cmd(input string nm, input logic [1:0] op, input logic [3:0] data, input bit hold,
                           input logic [3:0] ej, input logic [3:0] ek, input logic [3:0] eq, input logic ee);
        int  p0;
        bit  seen;
        chk({nm, " ready"}, cmd_ready, 1);
        p0 = pulses;
        cmd_op = op;
        cmd_data = data;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        chk({nm, " err cleared"}, err, 0);
        chk({nm, " busy"}, cmd_ready, 0);
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c >= 1 && c <= 3) begin
                chk($sformatf("%s j c%0d", nm, c), jk_j, ej);
                chk($sformatf("%s k c%0d", nm, c), jk_k, ek);
            end
            if (c <= 5) chk($sformatf("%s strobe c%0d", nm, c), jk_clk, (c == 2) ? 1 : 0);
            if (done) begin
                seen = 1;
                chk({nm, " latency"}, c, 6);
            end
        end
        if (!seen) chk({nm, " done timeout"}, 0, 1);
        chk({nm, " q_obs"}, q_obs, eq);
        chk({nm, " err"}, err, ee);
        chk({nm, " pulses"}, pulses - p0, 1);
        chk({nm, " jk released"}, {jk_j, jk_k}, 0);
        chk({nm, " ready at done"}, cmd_ready, 1);
        cmd_valid = 1'b0;
    endtask

    typedef struct {
        logic [1:0] op;
        logic [3:0] data;
        logic [3:0] stk;
        logic [3:0] j;
        logic [3:0] k;
        logic [3:0] q;
        logic       e;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [3:0] tgt, ej, ek;
        int p5;
        bit any_done;

        vecs[0] = '{2'b00, 4'hA, 4'h0, 4'hA, 4'h0, 4'hA, 1'b0};  // 0 -> LOAD A
        vecs[1] = '{2'b00, 4'hF, 4'h0, 4'h5, 4'h0, 4'hF, 1'b0};  // A -> LOAD F
        vecs[2] = '{2'b01, 4'h0, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0};  // F -> INC wraps
        vecs[3] = '{2'b10, 4'h0, 4'h0, 4'hF, 4'h0, 4'hF, 1'b0};  // 0 -> DEC wraps
        vecs[4] = '{2'b00, 4'hA, 4'h0, 4'h0, 4'h5, 4'hA, 1'b0};  // F -> LOAD A
        vecs[5] = '{2'b11, 4'h5, 4'h0, 4'h5, 4'h5, 4'hF, 1'b0};  // A ^ 5
        vecs[6] = '{2'b11, 4'h5, 4'h0, 4'h5, 4'h5, 4'hA, 1'b0};  // F ^ 5, back-to-back
        vecs[7] = '{2'b00, 4'h3, 4'h1, 4'h1, 4'h8, 4'h2, 1'b1};  // q_in[0] stuck low

        #2;
        chk("rst jk_clk", jk_clk, 0);
        chk("rst jk", {jk_j, jk_k}, 0);
        chk("rst done", done, 0);
        chk("rst err", err, 0);
        chk("rst q_obs", q_obs, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("rst ready", cmd_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            stuck = vecs[i].stk;
            if (i == 5) p5 = pulses;
            run_cmd($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, 1'b0,
                    vecs[i].j, vecs[i].k, vecs[i].q, vecs[i].e);
            if (i == 6) chk("toggle pair pulses", pulses - p5, 2);
        end

        // err persists through idle cycles, then clears on the next accept
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("err hold c%0d", c), err, 1);
        end
        stuck = '0;
        run_cmd("after err", 2'b00, 4'h0, 1'b0, 4'h0, 4'h3, 4'h0, 1'b0);

        // valid held through a busy command must not start a second one
        run_cmd("held valid", 2'b00, 4'h6, 1'b1, 4'h6, 4'h0, 4'h6, 1'b0);
        @(negedge clk);
        chk("held valid idle", cmd_ready, 1);

        // clr during STROBE
        cmd_op = 2'b00;
        cmd_data = 4'h9;
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre-clr strobe", jk_clk, 1);
        clr = 1'b1;
        #1;
        chk("clr jk_clk", jk_clk, 0);
        chk("clr jk", {jk_j, jk_k}, 0);
        chk("clr done", done, 0);
        @(negedge clk);
        clr = 1'b0;
        #1;
        chk("clr ready", cmd_ready, 1);
        any_done = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done) any_done = 1;
        end
        chk("clr no done", any_done, 0);
        chk("clr no err", err, 0);
        run_cmd("post clr", 2'b00, 4'h0, 1'b0, 4'h0, 4'h0, 4'h0, 1'b0);
        model_bank = 4'h0;

        for (int n = 0; n < 40; n++) begin
            logic [1:0] op;
            logic [3:0] d;
            op = 2'($urandom_range(0, 3));
            d  = 4'($urandom_range(0, 15));
            model(op, d, model_bank, tgt, ej, ek);
            run_cmd($sformatf("rnd%0d op%0d", n, op), op, d, 1'b0, ej, ek, tgt, 1'b0);
            model_bank = tgt;
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
